// File: rtl/bmem_line_bridge_if.sv
// Bus bundle for bmem_line_bridge: upstream cacheline port (ufp_*) and downstream bmem burst port.
// The slave modport is the bridge's view; master is the environment's (arbiter + memory) view.
interface bmem_line_bridge_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned BEATS  = 4
);
   logic [ADDR_W-1:0]   ufp_addr;
   logic                ufp_read;
   logic                ufp_write;
   logic [64*BEATS-1:0] ufp_wdata;
   logic [64*BEATS-1:0] ufp_rdata;
   logic                ufp_resp;

   logic [ADDR_W-1:0]   bmem_addr;
   logic                bmem_read;
   logic                bmem_write;
   logic [63:0]         bmem_wdata;
   logic                bmem_ready;
   logic [ADDR_W-1:0]   bmem_raddr;
   logic [63:0]         bmem_rdata;
   logic                bmem_rvalid;

   modport slave (
      input  ufp_addr, ufp_read, ufp_write, ufp_wdata,
      output ufp_rdata, ufp_resp,
      output bmem_addr, bmem_read, bmem_write, bmem_wdata,
      input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
   );

   modport master (
      output ufp_addr, ufp_read, ufp_write, ufp_wdata,
      input  ufp_rdata, ufp_resp,
      input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
      output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
   );
endinterface

// File: rtl/bmem_line_bridge.sv
// Converts one blocking cacheline request into 64-bit bmem bursts with stale-beat filtering.
// Define BMEM_LINE_PREFETCH_EN to add a one-entry next-line prefetch buffer.
module bmem_line_bridge #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned LINE_BYTES = 32,
   parameter int unsigned BEATS      = 4
) (
   input logic             clk,
   input logic             rst,
   bmem_line_bridge_if.slave bus
);
   localparam int unsigned LineW = 64 * BEATS;
   localparam int unsigned CntW  = $clog2(BEATS);
   localparam logic [ADDR_W-1:0] LineMask = ~ADDR_W'(LINE_BYTES - 1);
   localparam logic [CntW-1:0]   LastBeat = CntW'(BEATS - 1);

   typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWrBeat, StResp} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] line_q, line_d;
   logic [LineW-1:0]  wdata_q, wdata_d;
   logic [LineW-1:0]  rdata_q, rdata_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   logic [ADDR_W-1:0] req_line;
   logic [ADDR_W-1:0] next_line;
   logic              beat_hit;
   logic              dem_capture;

   logic              bmem_read, bmem_write, ufp_resp;
   logic [ADDR_W-1:0] bmem_addr;
   logic [63:0]       bmem_wdata;

   assign req_line  = bus.ufp_addr & LineMask;
   assign next_line = line_q + ADDR_W'(LINE_BYTES);
   assign beat_hit  = bus.bmem_rvalid && (bus.bmem_raddr == line_q);

`ifdef BMEM_LINE_PREFETCH_EN
   logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;
   logic [LineW-1:0]  pf_data_q, pf_data_d;
   logic              pf_valid_q, pf_valid_d;
   logic              pf_pend_q, pf_pend_d;
   logic [CntW-1:0]   pf_cnt_q, pf_cnt_d;
   logic              dem_issued_q, dem_issued_d;
   logic              hit_wait_q, hit_wait_d;

   // Demand beats may already arrive while the follow-up prefetch request is still pending.
   assign dem_capture = beat_hit && !hit_wait_q &&
                        ((state_q == StRdWait) || ((state_q == StRdReq) && dem_issued_q));
`else
   assign dem_capture = beat_hit && (state_q == StRdWait);
`endif

   always_comb begin
      state_d    = state_q;
      line_d     = line_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      cnt_d      = cnt_q;
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      bmem_addr  = '0;
      bmem_wdata = '0;
      ufp_resp   = 1'b0;
`ifdef BMEM_LINE_PREFETCH_EN
      pf_addr_d    = pf_addr_q;
      pf_data_d    = pf_data_q;
      pf_valid_d   = pf_valid_q;
      pf_pend_d    = pf_pend_q;
      pf_cnt_d     = pf_cnt_q;
      dem_issued_d = dem_issued_q;
      hit_wait_d   = hit_wait_q;

      if (pf_pend_q && bus.bmem_rvalid && (bus.bmem_raddr == pf_addr_q)) begin
         pf_data_d[64*pf_cnt_q +: 64] = bus.bmem_rdata;
         pf_cnt_d = pf_cnt_q + 1'b1;
         if (pf_cnt_q == LastBeat) begin
            pf_pend_d  = 1'b0;
            pf_valid_d = 1'b1;
         end
      end
`endif

      if (dem_capture) begin
         rdata_d[64*cnt_q +: 64] = bus.bmem_rdata;
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LastBeat) state_d = StResp;
      end

      unique case (state_q)
         StIdle: begin
            if (bus.ufp_read) begin
`ifdef BMEM_LINE_PREFETCH_EN
               if (pf_valid_q && (pf_addr_q == req_line)) begin
                  rdata_d = pf_data_q;
                  state_d = StResp;
               end else if (pf_pend_q && (pf_addr_q == req_line)) begin
                  line_d     = req_line;
                  hit_wait_d = 1'b1;
                  state_d    = StRdWait;
               end else if (!pf_pend_q) begin
                  line_d       = req_line;
                  dem_issued_d = 1'b0;
                  hit_wait_d   = 1'b0;
                  state_d      = StRdReq;
               end
`else
               line_d  = req_line;
               state_d = StRdReq;
`endif
            end else if (bus.ufp_write) begin
               line_d  = req_line;
               wdata_d = bus.ufp_wdata;
               cnt_d   = '0;
               state_d = StWrBeat;
`ifdef BMEM_LINE_PREFETCH_EN
               if (pf_addr_q == req_line) begin
                  pf_valid_d = 1'b0;
                  pf_pend_d  = 1'b0;
               end
`endif
            end
         end
         StRdReq: begin
            bmem_read = 1'b1;
`ifdef BMEM_LINE_PREFETCH_EN
            if (!dem_issued_q) begin
               bmem_addr = line_q;
               if (bus.bmem_ready) begin
                  cnt_d        = '0;
                  dem_issued_d = 1'b1;
                  if ((pf_addr_q == next_line) && (pf_valid_q || pf_pend_q)) state_d = StRdWait;
               end
            end else begin
               bmem_addr = next_line;
               // If the demand line already completed, the prefetch is simply abandoned.
               if (bus.bmem_ready && (state_d == StRdReq)) begin
                  pf_addr_d  = next_line;
                  pf_pend_d  = 1'b1;
                  pf_valid_d = 1'b0;
                  pf_cnt_d   = '0;
                  state_d    = StRdWait;
               end
            end
`else
            bmem_addr = line_q;
            if (bus.bmem_ready) begin
               cnt_d   = '0;
               state_d = StRdWait;
            end
`endif
         end
         StRdWait: begin
`ifdef BMEM_LINE_PREFETCH_EN
            if (hit_wait_q && pf_valid_q && (pf_addr_q == line_q)) begin
               rdata_d = pf_data_q;
               state_d = StResp;
            end
`endif
         end
         StWrBeat: begin
            bmem_write = 1'b1;
            bmem_addr  = line_q;
            bmem_wdata = wdata_q[64*cnt_q +: 64];
            if (bus.bmem_ready) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LastBeat) state_d = StResp;
            end
         end
         StResp: begin
            ufp_resp = 1'b1;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         line_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         line_q  <= line_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef BMEM_LINE_PREFETCH_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pf_addr_q    <= '0;
         pf_data_q    <= '0;
         pf_valid_q   <= 1'b0;
         pf_pend_q    <= 1'b0;
         pf_cnt_q     <= '0;
         dem_issued_q <= 1'b0;
         hit_wait_q   <= 1'b0;
      end else begin
         pf_addr_q    <= pf_addr_d;
         pf_data_q    <= pf_data_d;
         pf_valid_q   <= pf_valid_d;
         pf_pend_q    <= pf_pend_d;
         pf_cnt_q     <= pf_cnt_d;
         dem_issued_q <= dem_issued_d;
         hit_wait_q   <= hit_wait_d;
      end
   end
`endif

   assign bus.bmem_read  = bmem_read;
   assign bus.bmem_write = bmem_write;
   assign bus.bmem_addr  = bmem_addr;
   assign bus.bmem_wdata = bmem_wdata;
   assign bus.ufp_resp   = ufp_resp;
   assign bus.ufp_rdata  = rdata_q;
endmodule

// File: tb/tb_bmem_line_bridge.sv
// Directed self-checking bench for bmem_line_bridge (reads, held writes, stray beats, reset, stall).
module tb_bmem_line_bridge;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   rd_issues = 0;
   int   wr_beats  = 0;
   int   resp_cnt  = 0;
   logic both_seen = 1'b0;

`ifdef BMEM_LINE_PREFETCH_EN
   localparam int RdPerMiss = 2;
`else
   localparam int RdPerMiss = 1;
`endif

   bmem_line_bridge_if #(.ADDR_W(32), .BEATS(4)) bus ();

   bmem_line_bridge #(.ADDR_W(32), .LINE_BYTES(32), .BEATS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) begin
         if (bus.bmem_read && bus.bmem_ready)  rd_issues <= rd_issues + 1;
         if (bus.bmem_write && bus.bmem_ready) wr_beats  <= wr_beats + 1;
         if (bus.ufp_resp)                     resp_cnt  <= resp_cnt + 1;
         if (bus.bmem_read && bus.bmem_write)  both_seen <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bridge waiting for beats once every pending bmem_read is accepted.
   task automatic drain_req();
      for (int i = 0; i < 8 && bus.bmem_read; i++) step();
   endtask

   task automatic beat(input logic [31:0] raddr, input logic [63:0] data);
      bus.bmem_rvalid = 1'b1;
      bus.bmem_raddr  = raddr;
      bus.bmem_rdata  = data;
      step();
      bus.bmem_rvalid = 1'b0;
   endtask

   task automatic fill_prefetch(input logic [31:0] line);
`ifdef BMEM_LINE_PREFETCH_EN
      for (int i = 0; i < 4; i++) beat(line + 32'h20, {32'hFEED0000, line, 16'h0, 8'h0} ^ 64'(i));
`else
      if (line == 32'hFFFF_FFFF) $display("unused line %h", line);
`endif
   endtask

   logic [63:0]  a [4];
   logic [255:0] wline;
   int           r0;

   initial begin
      bus.ufp_addr = '0; bus.ufp_read = 1'b0; bus.ufp_write = 1'b0; bus.ufp_wdata = '0;
      bus.bmem_ready = 1'b1; bus.bmem_raddr = '0; bus.bmem_rdata = '0; bus.bmem_rvalid = 1'b0;

      #3;
      check("rst_rdata", bus.ufp_rdata, '0);
      check("rst_resp", 256'(bus.ufp_resp), 256'd0);
      check("rst_bmem_rw", 256'({bus.bmem_read, bus.bmem_write}), 256'd0);
      check("rst_bmem_addr", 256'(bus.bmem_addr), 256'd0);
      step();
      rst = 1'b1;
      step();

      // Read 0x1004: single request at the aligned line, beats A0..A3.
      a = '{64'hA0A0_0000_0000_0A00, 64'hA1A1_1111_1111_1A11, 64'hA2A2_2222_2222_2A22,
            64'hA3A3_3333_3333_3A33};
      r0 = rd_issues;
      bus.ufp_addr = 32'h0000_1004; bus.ufp_read = 1'b1;
      step();
      check("t1_bmem_read", 256'(bus.bmem_read), 256'd1);
      check("t1_bmem_addr", 256'(bus.bmem_addr), 256'h1000);
      drain_req();
      for (int i = 0; i < 3; i++) beat(32'h1000, a[i]);
      check("t1_no_early_resp", 256'(bus.ufp_resp), 256'd0);
      beat(32'h1000, a[3]);
      check("t1_resp", 256'(bus.ufp_resp), 256'd1);
      check("t1_rdata", bus.ufp_rdata, {a[3], a[2], a[1], a[0]});
      bus.ufp_read = 1'b0;
      step();
      check("t1_resp_one_cycle", 256'(bus.ufp_resp), 256'd0);
      check("t1_issues", 256'(rd_issues - r0), 256'(RdPerMiss));
      fill_prefetch(32'h1000);

      // Write 0x2000 with ready dropped for 3 cycles on beat 1.
      wline = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002, 64'hD1D1_0000_0000_0001,
               64'hD0D0_0000_0000_0000};
      r0 = wr_beats;
      bus.ufp_addr = 32'h2000; bus.ufp_wdata = wline; bus.ufp_write = 1'b1;
      step();
      check("t2_bmem_write", 256'(bus.bmem_write), 256'd1);
      check("t2_addr", 256'(bus.bmem_addr), 256'h2000);
      check("t2_beat0", 256'(bus.bmem_wdata), 256'(wline[63:0]));
      step();
      check("t2_beat1", 256'(bus.bmem_wdata), 256'(wline[127:64]));
      bus.bmem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t2_beat1_held", 256'({bus.bmem_write, bus.bmem_wdata}), {191'd0, 1'b1, wline[127:64]});
      end
      bus.bmem_ready = 1'b1;
      step();
      check("t2_beat2", 256'(bus.bmem_wdata), 256'(wline[191:128]));
      step();
      check("t2_beat3", 256'(bus.bmem_wdata), 256'(wline[255:192]));
      step();
      check("t2_resp", 256'({bus.ufp_resp, bus.bmem_write}), 256'b10);
      check("t2_rdata_unchanged", bus.ufp_rdata, {a[3], a[2], a[1], a[0]});
      bus.ufp_write = 1'b0;
      step();
      check("t2_beats", 256'(wr_beats - r0), 256'd4);
      check("t2_single_resp", 256'(bus.ufp_resp), 256'd0);

      // Read 0x3000 with a stray 0x5000 beat interleaved.
      bus.ufp_addr = 32'h3000; bus.ufp_read = 1'b1;
      step();
      drain_req();
      beat(32'h3000, 64'hB0);
      beat(32'h5000, 64'hDEAD_BEEF);
      beat(32'h3000, 64'hB1);
      beat(32'h3000, 64'hB2);
      beat(32'h3000, 64'hB3);
      check("t3_resp", 256'(bus.ufp_resp), 256'd1);
      check("t3_rdata", bus.ufp_rdata, {64'hB3, 64'hB2, 64'hB1, 64'hB0});
      check("t3_cnt_wrapped", 256'(dut.cnt_q), 256'd0);
      bus.ufp_read = 1'b0;
      step();
      fill_prefetch(32'h3000);

      // Reset after two beats of a read, then a clean read of 0x4000.
      bus.ufp_addr = 32'h7000; bus.ufp_read = 1'b1;
      step();
      drain_req();
      beat(32'h7000, 64'h77);
      beat(32'h7000, 64'h78);
      #2 rst = 1'b0;
      #1;
      check("t4_rst_rdata", bus.ufp_rdata, '0);
      check("t4_rst_outs", 256'({bus.bmem_read, bus.bmem_write, bus.ufp_resp}), 256'd0);
      bus.ufp_read = 1'b0;
      step();
      rst = 1'b1;
      step();
      bus.ufp_addr = 32'h4000; bus.ufp_read = 1'b1;
      step();
      check("t4_new_addr", 256'(bus.bmem_addr), 256'h4000);
      drain_req();
      for (int i = 0; i < 4; i++) beat(32'h4000, 64'hC0 + 64'(i));
      check("t4_resp", 256'(bus.ufp_resp), 256'd1);
      check("t4_rdata", bus.ufp_rdata, {64'hC3, 64'hC2, 64'hC1, 64'hC0});
      bus.ufp_read = 1'b0;
      step();
      fill_prefetch(32'h4000);

      // Request stalled by ready=0 for 5 cycles.
      r0 = rd_issues;
      bus.bmem_ready = 1'b0;
      bus.ufp_addr = 32'h8008; bus.ufp_read = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t5_held", 256'({bus.bmem_read, bus.ufp_resp, bus.bmem_addr}), {222'd0, 2'b10, 32'h8000});
      end
      bus.bmem_ready = 1'b1;
      step();
      drain_req();
      for (int i = 0; i < 4; i++) beat(32'h8000, 64'hE0 + 64'(i));
      check("t5_resp", 256'(bus.ufp_resp), 256'd1);
      check("t5_issues", 256'(rd_issues - r0), 256'(RdPerMiss));
      bus.ufp_read = 1'b0;
      step();
      fill_prefetch(32'h8000);

`ifdef BMEM_LINE_PREFETCH_EN
      // Next-line prefetch: 0x6020 served from the buffer one cycle after request.
      r0 = rd_issues;
      bus.ufp_addr = 32'h6000; bus.ufp_read = 1'b1;
      step();
      drain_req();
      for (int i = 0; i < 4; i++) beat(32'h6000, 64'h60 + 64'(i));
      check("pf_demand_resp", 256'(bus.ufp_resp), 256'd1);
      bus.ufp_read = 1'b0;
      step();
      for (int i = 0; i < 4; i++) beat(32'h6020, 64'h620 + 64'(i));
      bus.ufp_addr = 32'h6020; bus.ufp_read = 1'b1;
      step();
      check("pf_hit_resp", 256'(bus.ufp_resp), 256'd1);
      check("pf_hit_rdata", bus.ufp_rdata, {64'h623, 64'h622, 64'h621, 64'h620});
      bus.ufp_read = 1'b0;
      step();
      check("pf_issues", 256'(rd_issues - r0), 256'd2);
`endif

      check("never_rd_and_wr", 256'(both_seen), 256'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
